// File: rtl/fp_pkg.sv
// fp_pkg: shared float formats and helpers for the layer datapath
// used by the bias-add pipe and the multiplier path
package fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  typedef struct packed {
    logic                sgn;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } float_24_8;

  function automatic float_24_8 fp_unpack(
    input logic [FP_EXP_W+FP_MAN_W:0] bits
  );
    return float_24_8'(bits);
  endfunction

  function automatic logic [FP_EXP_W+FP_MAN_W:0] fp_pack(
    input float_24_8 f
  );
    return {f.sgn, f.exp, f.man};
  endfunction

endpackage

// File: rtl/fp_norm_round.sv
// fp_norm_round: leading-one detect, normalise and round-to-nearest-even
// FP_BIAS_ADD_SAT_EN clamps exponent overflow to max finite
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int EXP_W     = FP_EXP_W,
  parameter int MAN_W     = FP_MAN_W,
  parameter int FLUSH_EXP = 10
) (
  input  logic               sgn,
  input  logic [2*MAN_W+2:0] mag,
  input  logic [EXP_W-1:0]   exp_max,
  output logic [EXP_W+MAN_W:0] res,
  output logic               flush
);

  localparam int N  = 2 * MAN_W + 3;
  localparam int PW = $clog2(MAN_W + 2);
  localparam int XW = EXP_W + 2;
`ifdef FP_BIAS_ADD_SAT_EN
  localparam logic signed [XW-1:0] EXP_TOP =
    XW'((1 << EXP_W) - 2);
`endif

  logic             found;
  logic [PW-1:0]    pos;
  logic [N-1:0]     norm;
  logic             rnd;
  logic [MAN_W:0]   man_r;
  logic [XW-1:0]    exp_n;
  logic [EXP_W-1:0] exp_o;
  logic [MAN_W-1:0] man_o;
  logic             unused_bits;

  // first set bit below the MSB; pos 0 means a carry out of the add
  always_comb begin
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i <= MAN_W; i++) begin
      if (!found && mag[N-2-i]) begin
        found = 1'b1;
        pos   = PW'(i);
      end
    end
  end

  // shift to the hidden bit, round, then fix the exponent
  always_comb begin
    norm  = mag << pos;
    rnd   = norm[MAN_W] &
            (norm[MAN_W+1] | (|norm[MAN_W-1:0]));
    man_r = {1'b0, norm[N-3 -: MAN_W]} +
            {{MAN_W{1'b0}}, rnd};
    exp_n = XW'(exp_max) + XW'(1) - XW'(pos) +
            XW'(man_r[MAN_W]);
    exp_o = exp_n[EXP_W-1:0];
    man_o = man_r[MAN_W-1:0];
`ifdef FP_BIAS_ADD_SAT_EN
    if ($signed(exp_n) > EXP_TOP) begin
      exp_o = EXP_TOP[EXP_W-1:0];
      man_o = '1;
    end
`endif
    flush = !found || (exp_max < EXP_W'(FLUSH_EXP));
    res   = flush ? '0 : {sgn, exp_o, man_o};
  end

  assign unused_bits = ^{norm[N-1:N-2], exp_n[XW-1:EXP_W]};

endmodule

// File: rtl/fp_bias_add_pipe.sv
// fp_bias_add_pipe: 2-stage float adder, data + (sub ? -bias : bias)
// define FP_BIAS_ADD_SAT_EN to clamp exponent overflow to max finite
module fp_bias_add_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W     = FP_EXP_W,
  parameter int MAN_W     = FP_MAN_W,
  parameter int FLUSH_EXP = 10,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_data,
  input  logic [EXP_W+MAN_W:0]   in_bias,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic [CNT_W-1:0]       flush_cnt,
  input  logic                   flush_clr
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 3;
  localparam int N  = 2 * MAN_W + 3;

  logic [EXP_W-1:0]    exp_a;
  logic [EXP_W-1:0]    exp_b;
  logic [EXP_W-1:0]    exp_big;
  logic [EXP_W:0]      del;
  logic [EXP_W:0]      shift;
  logic                b_big;
  logic [MW-1:0]       man_a;
  logic [MW-1:0]       man_b;
  logic [MW-1:0]       big_m;
  logic [MW-1:0]       sml_m;
  logic signed [N-1:0] big_x;
  logic signed [N-1:0] sml_x;
  logic signed [N-1:0] sum;
  logic [N-1:0]        mag;

  logic                s1_valid;
  logic                s1_sgn;
  logic [N-1:0]        s1_mag;
  logic [EXP_W-1:0]    s1_exp;

  logic [W-1:0]        nr_res;
  logic                nr_flush;
  logic                out_flush;
  logic                out_adv;

  // align the smaller-exponent operand and sum signed mantissas
  always_comb begin
    exp_a   = in_data[W-2 -: EXP_W];
    exp_b   = in_bias[W-2 -: EXP_W];
    del     = {1'b0, exp_a} - {1'b0, exp_b};
    b_big   = del[EXP_W];
    shift   = b_big ? -del : del;
    exp_big = b_big ? exp_b : exp_a;
    man_a   = {2'b01, in_data[MAN_W-1:0]};
    man_b   = {2'b01, in_bias[MAN_W-1:0]};
    if (in_data[W-1]) man_a = -man_a;
    if (in_bias[W-1] ^ in_sub) man_b = -man_b;
    big_m   = b_big ? man_b : man_a;
    sml_m   = b_big ? man_a : man_b;
    big_x   = {big_m, {MAN_W{1'b0}}};
    sml_x   = $signed({sml_m, {MAN_W{1'b0}}}) >>> shift;
    sum     = big_x + sml_x;
    mag     = sum[N-1] ? -sum : sum;
  end

  assign out_adv  = out_ready | ~out_valid;
  assign in_ready = ~s1_valid | out_adv;

  // stage 1: hold sign, magnitude and exponent of the aligned sum
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_sgn   <= 1'b0;
      s1_mag   <= '0;
      s1_exp   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sgn <= sum[N-1];
        s1_mag <= mag;
        s1_exp <= exp_big;
      end
    end
  end

  fp_norm_round #(
    .EXP_W     (EXP_W),
    .MAN_W     (MAN_W),
    .FLUSH_EXP (FLUSH_EXP)
  ) u_norm (
    .sgn     (s1_sgn),
    .mag     (s1_mag),
    .exp_max (s1_exp),
    .res     (nr_res),
    .flush   (nr_flush)
  );

  // stage 2: rounded result, held while downstream stalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flush <= 1'b0;
    end else if (out_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data  <= nr_res;
        out_flush <= nr_flush;
      end
    end
  end

  // count flushed results as they leave; clear wins over increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_cnt <= '0;
    end else if (flush_clr) begin
      flush_cnt <= '0;
    end else if (out_valid && out_ready && out_flush &&
                 flush_cnt != '1) begin
      flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fp_bias_add_pipe.sv
// tb_fp_bias_add_pipe: directed and random checks of the bias-add pipe
// expected results come from an integer model of the float rules
module tb_fp_bias_add_pipe;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [31:0] in_bias = '0;
  logic        in_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [15:0] flush_cnt;
  logic        flush_clr = 1'b0;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_acc = 0;
  int          exp_cnt = 0;
  logic        acc_last = 1'b0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_d = '0;
  logic [32:0] cur_exp = '0;
  string       cur_tag = "none";
  logic [32:0] q[$];
  string       qt[$];

  always #5 clk = ~clk;

  fp_bias_add_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_bias   (in_bias),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush_cnt (flush_cnt),
    .flush_clr (flush_clr)
  );

  // {flushed, result}: align, add, round-half-even on integers
  function automatic logic [32:0] ref_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s
  );
    int     ea, eb, d, sh, emax, q1, e;
    longint va, vb, big, sml, sm, mg, man, rem, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    va = longint'({1'b1, a[22:0]});
    vb = longint'({1'b1, b[22:0]});
    if (a[31]) va = -va;
    if (b[31] ^ s) vb = -vb;
    d    = ea - eb;
    sh   = (d < 0) ? -d : d;
    emax = (d < 0) ? eb : ea;
    big  = ((d < 0) ? vb : va) * 8388608;
    sml  = ((d < 0) ? va : vb) * 8388608;
    if (sh > 62) sml = (sml < 0) ? -1 : 0;
    else sml = sml >>> sh;
    sm = big + sml;
    mg = (sm < 0) ? -sm : sm;
    if (emax < 10 || mg < (longint'(1) << 24))
      return {1'b1, 32'h0};
    q1 = 47;
    while (mg < (longint'(1) << q1)) q1--;
    e    = emax + q1 - 46;
    man  = (mg >>> (q1 - 23)) - (longint'(1) << 23);
    rem  = mg - ((mg >>> (q1 - 23)) <<< (q1 - 23));
    half = longint'(1) << (q1 - 24);
    if (rem > half || (rem == half && (man % 2) == 1))
      man++;
    if (man == (longint'(1) << 23)) begin
      man = 0;
      e++;
    end
`ifdef FP_BIAS_ADD_SAT_EN
    if (e > 254) return {1'b0, sm < 0, 8'd254, 23'h7fffff};
`endif
    return {1'b0, sm < 0, 8'(e), 23'(man)};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] want
  );
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, want);
    end
  endtask

  // one clock: score outputs, log accepts, advance past the edge
  task automatic step();
    logic [32:0] e;
    string       t;
    #1;
    if (hold_v) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", out_data, hold_d);
    end
    hold_v = out_valid && !out_ready;
    hold_d = out_data;
    if (out_valid && out_ready) begin
      n_cmp++;
      assert (q.size() > 0) else begin
        n_bad++;
        $error("FAIL extra_out: got %h want none", out_data);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        t = qt.pop_front();
        chk(t, out_data, e[31:0]);
        if (e[32] && !flush_clr && exp_cnt < 65535)
          exp_cnt++;
      end
    end
    if (flush_clr) exp_cnt = 0;
    acc_last = in_valid && in_ready;
    if (acc_last) begin
      q.push_back(cur_exp);
      qt.push_back(cur_tag);
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s,
    input logic [32:0] want,
    input string       tag
  );
    in_data  = a;
    in_bias  = b;
    in_sub   = s;
    in_valid = 1'b1;
    cur_exp  = want;
    cur_tag  = tag;
    acc_last = 1'b0;
    for (int i = 0; i < 20 && !acc_last; i++) step();
    in_valid = 1'b0;
    n_cmp++;
    assert (acc_last) else begin
      n_bad++;
      $error("FAIL %s_accept: got none want accept", tag);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (q.size() > 0 || out_valid); i++)
      step();
    n_cmp++;
    assert (q.size() == 0) else begin
      n_bad++;
      $error("FAIL drain: got %0d left want 0", q.size());
    end
  endtask

  task automatic new_rand();
    float_24_8   fa, fb;
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb;
    ea = 8'($urandom_range(0, 255));
    if ($urandom_range(0, 1) == 1) eb = 8'($urandom_range(0, 255));
    else eb = ea ^ 8'($urandom_range(0, 3));
    ma = 23'($urandom);
    mb = ($urandom_range(0, 7) == 0) ? ma : 23'($urandom);
    fa = '{sgn: 1'($urandom), exp: ea, man: ma};
    fb = '{sgn: 1'($urandom), exp: eb, man: mb};
    in_data = fp_pack(fa);
    in_bias = fp_pack(fb);
    in_sub  = 1'($urandom);
    cur_exp = ref_add(in_data, in_bias, in_sub);
    cur_tag = "rand";
  endtask

  initial begin
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    send(32'h3FC00000, 32'h40100000, 1'b0,
         {1'b0, 32'h40700000}, "basic");
    chk("lat_1", 32'(out_valid), 32'd0);
    step();
    chk("lat_2", 32'(out_valid), 32'd1);
    drain();
    chk("cnt_basic", 32'(flush_cnt), 32'd0);

    send(32'h3F800000, 32'h3F800000, 1'b1,
         {1'b1, 32'h0}, "sub_zero");
    drain();
    chk("cnt_sub_zero", 32'(flush_cnt), 32'd1);

    send(32'h02800000, 32'h02800000, 1'b0,
         {1'b1, 32'h0}, "underflow");
    drain();
    chk("cnt_underflow", 32'(flush_cnt), 32'd2);

    send(32'h02800000, 32'h02900000, 1'b0,
         {1'b1, 32'h0}, "uf_clr");
    step();
    flush_clr = 1'b1;
    step();
    flush_clr = 1'b0;
    chk("clr_priority", 32'(flush_cnt), 32'd0);

    send(32'h3FFFFFFF, 32'h33800000, 1'b0,
         {1'b0, 32'h40000000}, "round_carry");
    drain();

`ifdef FP_BIAS_ADD_SAT_EN
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0,
         {1'b0, 32'h7F7FFFFF}, "overflow");
`else
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0,
         {1'b0, 32'h7FFFFFFF}, "overflow");
`endif
    drain();

    n_acc = 0;
    out_ready = 1'b1;
    new_rand();
    cur_tag = "bp";
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (acc_last) begin
        new_rand();
        cur_tag = "bp";
      end
    end
    out_ready = 1'b0;
    #1;
    chk("bp_accepts", 32'(n_acc), 32'd3);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    repeat (4) step();
    chk("bp_no_accept", 32'(n_acc), 32'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && n_acc < 6; i++) begin
      step();
      if (acc_last) begin
        new_rand();
        cur_tag = "bp";
      end
    end
    in_valid = 1'b0;
    drain();
    chk("bp_total", 32'(n_acc), 32'd6);

    acc_last = 1'b0;
    new_rand();
    for (int i = 0; i < 400; i++) begin
      if (acc_last) new_rand();
      if (acc_last || !in_valid)
        in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush_clr = ($urandom_range(0, 49) == 0);
      step();
    end
    in_valid = 1'b0;
    flush_clr = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("rand_cnt", 32'(flush_cnt), 32'(exp_cnt));

    out_ready = 1'b0;
    send(32'h3FC00000, 32'h40100000, 1'b0,
         {1'b0, 32'h40700000}, "inflight_a");
    send(32'h3F800000, 32'h3F800000, 1'b0,
         {1'b0, 32'h40000000}, "inflight_b");
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_cnt", 32'(flush_cnt), 32'd0);
    q.delete();
    qt.delete();
    hold_v = 1'b0;
    exp_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (5) step();
    chk("post_rst_quiet", 32'(out_valid), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
